systolic_seq_ctrl: RTL and testbench
====================================

// Module: systolic_seq_ctrl
// PURPOSE
//  Sequencer for the NxN systolic PE array: computes C = A x B with inner dimension k_len.
//  Issues skewed A/B operand-buffer reads, clears array accumulators and schedules drain.
//  Writes result rows to the result buffer with a valid/ready handshake.
//  Sits between the RISC-V coprocessor CSR interface (start/done) and the PE array plus its buffers.
// PARAMETERS
//  N         4      array dimension (rows = cols = N)
//  K_MAX     64     maximum inner dimension accepted on k_len
//  DRAIN_LAT 2*N    cycles from last feed cycle until the final PE partial sum is stable
// PORTS
//  clk          in   1        single clock; all logic on posedge
//  reset        in   1        synchronous, active-high; all state/outputs cleared
//  start        in   1        request; sampled only in IDLE
//  k_len        in   KW       inner dimension, KW=$clog2(K_MAX+1); captured when start is accepted
//  busy         out  1        1 in CLEAR/FEED/DRAIN/WRITE
//  done         out  1        one-cycle pulse in DONE
//  err          out  1        valid with done; 1 = k_len was 0 or > K_MAX
//  array_clr    out  1        clears all PE accumulators/regs (one cycle, CLEAR state)
//  a_vld        out  N        per-row operand valid; 0 => inject zero into row i
//  a_rd_addr    out  N*KW     per-row k index into A buffer (row i in bits [i*KW +: KW])
//  b_vld        out  N        per-column operand valid; 0 => inject zero into column j
//  b_rd_addr    out  N*KW     per-column k index into B buffer
//  res_wr_valid out  1        result row capture request
//  res_wr_ready in   1        result buffer accepts a row
//  res_wr_row   out  $clog2(N) index of the row being written
//  perf_cycles  out  32       cycle count of the last op (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=IDLE; every output 0; internal counters 0.
//  - FSM: IDLE -> CLEAR -> FEED -> DRAIN -> WRITE -> DONE -> IDLE.
//  - IDLE: start=1 with 1<=k_len<=K_MAX: latch k_len, go to CLEAR.
//    Invalid k_len: go straight to DONE with err=1; no array/buffer activity.
//  - start while not in IDLE is ignored; no queuing.
//  - CLEAR: one cycle, array_clr=1.
//  - FEED: t counts 0..k_len+N-2 (k_len+N-1 cycles).
//    Row i: a_vld[i] = (t>=i && t-i<k_len), a_rd_addr[i] = t-i.
//    Column j: same rule with j.
//    When a valid bit is 0, its address field is driven 0.
//  - DRAIN: exactly DRAIN_LAT cycles; all vld=0.
//  - WRITE: res_wr_valid=1, res_wr_row=r starting at r=0.
//    A row transfers on a cycle with valid&&ready; r then increments.
//    Leave WRITE after the transfer with r=N-1.
//    ready=0 stalls: row and valid are held and the array is untouched.
//  - DONE: one cycle with done=1 and busy=0; err is valid this cycle and 0 otherwise. Then IDLE.
//  - Latency (valid op): done is asserted 1+(k_len+N-1)+DRAIN_LAT+N+1 cycles after start is sampled, plus any ready stalls.
//  - reset asserted mid-operation: abort on the next edge to reset state.
//    No done pulse; the partial result is discarded.
//  - Counters are KW/$clog2 wide with no wrap; t never exceeds K_MAX+N-2.
// CONFIGURATION
//  PERF_CNT_EN defined:
//   - A 32-bit counter clears when start is accepted, increments in every non-IDLE cycle including DONE, and saturates at 2^32-1.
//   - perf_cycles updates at DONE and holds until the next DONE.
//   - For an invalid k_len it equals 1.
//  PERF_CNT_EN undefined: perf_cycles tied to 0; no counter logic.
// STRUCTURE
//  - Shared package systolic_pkg: state encoding localparams (IDLE..DONE), KW derivation function, DRAIN_LAT default.
//  - The PE-array top imports the same package.
//  - Sub-module skew_idx_gen (instantiated twice, for A rows and B columns): t, k_len -> N vld bits + N packed indices; purely combinational.
//  - This block holds the FSM, t/r counters and perf counter.
// TESTING (N=4, DRAIN_LAT=8 unless noted)
//  1. start, k_len=4, ready=1:
//     array_clr at cycle 1; FEED cycles 2-8; a_vld sequence 0001,0011,0111,1111,1110,1100,1000; rows 0-3 on cycles 17-20; done at 21; perf_cycles=21.
//  2. k_len=1: FEED 4 cycles, each row vld exactly once at t=i with addr 0; done at cycle 18.
//  3. ready low for 3 cycles at row 2: res_wr_row holds 2 with valid=1; done is delayed by exactly 3 cycles.
//  4. k_len=0, and separately k_len=65: done+err at cycle 1; no array_clr, vld or res_wr_valid seen.
//  5. start pulses during FEED/WRITE are ignored; reset at a FEED cycle: all outputs 0 next cycle, no done.
//  6. PERF_CNT_EN undefined: perf_cycles==0 throughout scenario 1; cycle timing identical.

Source files
------------

// File: rtl/systolic_pkg.sv
// ----------------------------------------------------------------------------
// systolic_pkg
// Shared definitions for the NxN systolic array sequencer and the PE-array top:
// default array geometry, sequencer state encoding and width helpers.
// ----------------------------------------------------------------------------
package systolic_pkg;

  localparam int N_DEF         = 4;
  localparam int K_MAX_DEF     = 64;
  localparam int DRAIN_LAT_DEF = 2 * N_DEF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } seq_state_t;

  // Width of a k index / k_len field able to hold 0..k_max.
  function automatic int calc_kw(input int k_max);
    return $clog2(k_max + 1);
  endfunction

  // Width of an index over n entries, never narrower than one bit.
  function automatic int calc_iw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/systolic_seq_ctrl_skew_idx_gen.sv
// ----------------------------------------------------------------------------
// skew_idx_gen
// Purely combinational skew generator for one side of the systolic array.
// Lane i sees operand index t-i while 0 <= t-i < k_len; otherwise the lane is
// invalid (zero is injected) and its index field is forced to 0.
// Ports:
//   t     in  TW      current feed step
//   k_len in  KW      inner dimension of the running op
//   vld   out N       per-lane operand valid
//   idx   out N*KW    per-lane k index, lane i in bits [i*KW +: KW]
// ----------------------------------------------------------------------------
module skew_idx_gen
  import systolic_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int KW = calc_kw(K_MAX_DEF),
  parameter int TW = $clog2(K_MAX_DEF + N_DEF - 1)
) (
  input  logic [TW-1:0]   t,
  input  logic [KW-1:0]   k_len,
  output logic [N-1:0]    vld,
  output logic [N*KW-1:0] idx
);

  logic [TW-1:0] diff;

  // Per-lane skew: lane i lags the feed step by i cycles.
  always_comb begin
    vld  = '0;
    idx  = '0;
    diff = '0;
    for (int i = 0; i < N; i++) begin
      diff = t - TW'(i);
      if ((t >= TW'(i)) && (diff < TW'(k_len))) begin
        vld[i]            = 1'b1;
        idx[i*KW +: KW]   = diff[KW-1:0];
      end else begin
        vld[i]            = 1'b0;
        idx[i*KW +: KW]   = '0;
      end
    end
  end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// ----------------------------------------------------------------------------
// systolic_seq_ctrl
// Sequencer for the NxN systolic PE array computing C = A x B (inner dim k_len).
// Sequence: IDLE -> CLEAR -> FEED -> DRAIN -> WRITE -> DONE -> IDLE.
// An out-of-range k_len jumps straight from IDLE to DONE with err set.
// Optional feature macro: PERF_CNT_EN (32-bit op cycle counter on perf_cycles;
// when undefined perf_cycles is tied to 0).
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   start, k_len         op request (sampled in IDLE) and inner dimension
//   busy, done, err      status: busy in CLEAR..WRITE, done pulse, error flag
//   array_clr            one-cycle PE accumulator clear
//   a_vld, a_rd_addr     per-row A operand valid / k index
//   b_vld, b_rd_addr     per-column B operand valid / k index
//   res_wr_valid/ready   result row handshake, res_wr_row = row index
//   perf_cycles          cycle count of the last completed op
// All outputs are driven from flops.
// ----------------------------------------------------------------------------
module systolic_seq_ctrl
  import systolic_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int K_MAX     = K_MAX_DEF,
  parameter int DRAIN_LAT = 2 * N,
  parameter int KW        = calc_kw(K_MAX)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [KW-1:0]          k_len,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   array_clr,
  output logic [N-1:0]           a_vld,
  output logic [N*KW-1:0]        a_rd_addr,
  output logic [N-1:0]           b_vld,
  output logic [N*KW-1:0]        b_rd_addr,
  output logic                   res_wr_valid,
  input  logic                   res_wr_ready,
  output logic [calc_iw(N)-1:0]  res_wr_row,
  output logic [31:0]            perf_cycles
);

  localparam int TW = $clog2(K_MAX + N - 1);
  localparam int RW = calc_iw(N);
  localparam int DW = calc_iw(DRAIN_LAT);

  seq_state_t    state;
  logic [KW-1:0] k_r;
  logic [TW-1:0] t;
  logic [TW-1:0] t_last;
  logic [DW-1:0] dcnt;

  // Feed-step lookahead so the operand outputs can be registered.
  logic          feed_nxt;
  logic [TW-1:0] t_nxt;
  logic [N-1:0]  a_vld_s;
  logic [N-1:0]  b_vld_s;
  logic [N*KW-1:0] a_idx_s;
  logic [N*KW-1:0] b_idx_s;

  assign t_last = TW'(k_r) + TW'(N - 2);

  // Feed step and valid flag that the next cycle will present.
  always_comb begin
    feed_nxt = 1'b0;
    t_nxt    = '0;
    if (state == S_CLEAR) begin
      feed_nxt = 1'b1;
      t_nxt    = '0;
    end else if ((state == S_FEED) && (t != t_last)) begin
      feed_nxt = 1'b1;
      t_nxt    = t + TW'(1);
    end else begin
      feed_nxt = 1'b0;
      t_nxt    = '0;
    end
  end

  skew_idx_gen #(.N(N), .KW(KW), .TW(TW)) u_skew_a (
    .t     (t_nxt),
    .k_len (k_r),
    .vld   (a_vld_s),
    .idx   (a_idx_s)
  );

  skew_idx_gen #(.N(N), .KW(KW), .TW(TW)) u_skew_b (
    .t     (t_nxt),
    .k_len (k_r),
    .vld   (b_vld_s),
    .idx   (b_idx_s)
  );

  // Sequencer FSM with its counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      k_r          <= '0;
      t            <= '0;
      dcnt         <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      array_clr    <= 1'b0;
      a_vld        <= '0;
      a_rd_addr    <= '0;
      b_vld        <= '0;
      b_rd_addr    <= '0;
      res_wr_valid <= 1'b0;
      res_wr_row   <= '0;
    end else begin
      done      <= 1'b0;
      err       <= 1'b0;
      array_clr <= 1'b0;
      a_vld     <= feed_nxt ? a_vld_s : '0;
      a_rd_addr <= feed_nxt ? a_idx_s : '0;
      b_vld     <= feed_nxt ? b_vld_s : '0;
      b_rd_addr <= feed_nxt ? b_idx_s : '0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if ((k_len != '0) && (k_len <= KW'(K_MAX))) begin
              k_r       <= k_len;
              state     <= S_CLEAR;
              array_clr <= 1'b1;
              busy      <= 1'b1;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_CLEAR: begin
          state <= S_FEED;
          t     <= '0;
        end
        S_FEED: begin
          if (t == t_last) begin
            state <= S_DRAIN;
            t     <= '0;
            dcnt  <= '0;
          end else begin
            t <= t + TW'(1);
          end
        end
        S_DRAIN: begin
          if (dcnt == DW'(DRAIN_LAT - 1)) begin
            state        <= S_WRITE;
            dcnt         <= '0;
            res_wr_valid <= 1'b1;
            res_wr_row   <= '0;
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        S_WRITE: begin
          // A stalled row keeps valid and index until the buffer accepts it.
          if (res_wr_ready) begin
            if (res_wr_row == RW'(N - 1)) begin
              state        <= S_DONE;
              res_wr_valid <= 1'b0;
              res_wr_row   <= '0;
              busy         <= 1'b0;
              done         <= 1'b1;
            end else begin
              res_wr_row <= res_wr_row + RW'(1);
            end
          end else begin
            res_wr_row <= res_wr_row;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          k_r   <= '0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef PERF_CNT_EN
  logic [31:0] perf_cnt;
  logic [31:0] perf_q;

  // Op cycle counter: counts every non-IDLE cycle, published after DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cnt <= 32'd0;
      perf_q   <= 32'd0;
    end else begin
      if (state == S_IDLE) begin
        if (start) begin
          perf_cnt <= 32'd0;
        end else begin
          perf_cnt <= perf_cnt;
        end
      end else if (perf_cnt != 32'hFFFF_FFFF) begin
        perf_cnt <= perf_cnt + 32'd1;
      end else begin
        perf_cnt <= perf_cnt;
      end
      // The DONE cycle itself is part of the op, hence the +1.
      if (state == S_DONE) begin
        perf_q <= (perf_cnt == 32'hFFFF_FFFF) ? perf_cnt : perf_cnt + 32'd1;
      end else begin
        perf_q <= perf_q;
      end
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_systolic_seq_ctrl
// Scoreboard bench for systolic_seq_ctrl (N=4, K_MAX=64, DRAIN_LAT=8).
// Each op pushes its expected events (clear, feed beats, row writes, done)
// with their cycle numbers; the monitor pops and compares them as the DUT
// produces them. Cycle 0 is the cycle in which start is sampled.
// ----------------------------------------------------------------------------
module tb_systolic_seq_ctrl;

  localparam int N     = 4;
  localparam int K_MAX = 64;
  localparam int KW    = 7;
  localparam int D     = 8;
  localparam int RW    = 2;

  localparam int EV_CLR  = 0;
  localparam int EV_FEED = 1;
  localparam int EV_ROW  = 2;
  localparam int EV_DONE = 3;

  typedef struct {
    int              kind;
    int              cyc;
    logic [N-1:0]    vld;
    logic [N*KW-1:0] addr;
    int              row;
    logic            err;
  } ev_t;

  logic            clk;
  logic            reset;
  logic            start;
  logic [KW-1:0]   k_len;
  logic            busy;
  logic            done;
  logic            err;
  logic            array_clr;
  logic [N-1:0]    a_vld;
  logic [N*KW-1:0] a_rd_addr;
  logic [N-1:0]    b_vld;
  logic [N*KW-1:0] b_rd_addr;
  logic            res_wr_valid;
  logic            res_wr_ready;
  logic [RW-1:0]   res_wr_row;
  logic [31:0]     perf_cycles;

  int  total = 0;
  int  bad   = 0;
  ev_t sb[$];
  logic [N-1:0] s1_seq [7];

  systolic_seq_ctrl #(.N(N), .K_MAX(K_MAX), .DRAIN_LAT(D), .KW(KW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .k_len        (k_len),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .array_clr    (array_clr),
    .a_vld        (a_vld),
    .a_rd_addr    (a_rd_addr),
    .b_vld        (b_vld),
    .b_rd_addr    (b_rd_addr),
    .res_wr_valid (res_wr_valid),
    .res_wr_ready (res_wr_ready),
    .res_wr_row   (res_wr_row),
    .perf_cycles  (perf_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic void sb_push(input int kind, input int cyc, input logic [N-1:0] v,
                                  input logic [N*KW-1:0] a, input int row, input logic e,
                                  input int ac);
    ev_t x;
    if (ac < 0 || cyc <= ac) begin
      x.kind = kind; x.cyc = cyc; x.vld = v; x.addr = a; x.row = row; x.err = e;
      sb.push_back(x);
    end
  endfunction

  task automatic sb_take(input int kind, input int cyc);
    ev_t x;
    chk("sb_has_event", 64'(sb.size() > 0), 64'd1);
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk("ev_kind", 64'(kind), 64'(x.kind));
      chk("ev_cycle", 64'(cyc), 64'(x.cyc));
      if (x.kind == EV_FEED) begin
        chk("a_vld", a_vld, x.vld);
        chk("a_rd_addr", a_rd_addr, x.addr);
        chk("b_vld", b_vld, x.vld);
        chk("b_rd_addr", b_rd_addr, x.addr);
      end else if (x.kind == EV_ROW) begin
        chk("res_wr_row", res_wr_row, 64'(x.row));
      end else if (x.kind == EV_DONE) begin
        chk("done_err", err, x.err);
      end
    end
  endtask

  // k: inner dim; sr/ns: stall row and stall length; ac: cycle whose edge samples
  // reset (-1 = none); xs: extra ignored start pulses; s1: check literal a_vld sequence.
  task automatic run_op(input int k, input int sr, input int ns, input int ac,
                        input bit xs, input bit s1);
    bit              ok;
    int              feed_n, w0, st0, done_c, end_c, dd;
    logic [N-1:0]    v;
    logic [N*KW-1:0] a;
    bit              exp_busy, exp_wv;
    ok     = (k >= 1 && k <= K_MAX);
    feed_n = k + N - 1;
    w0     = 2 + feed_n + D;
    st0    = w0 + sr;
    done_c = ok ? (w0 + N + ns) : 1;
    end_c  = (ac >= 0) ? (ac + 20) : (done_c + 3);
    sb.delete();
    if (ok) begin
      sb_push(EV_CLR, 1, '0, '0, 0, 1'b0, ac);
      for (int t = 0; t < feed_n; t++) begin
        v = '0; a = '0;
        for (int i = 0; i < N; i++) begin
          if (t >= i && (t - i) < k) begin
            v[i] = 1'b1;
            a[i*KW +: KW] = KW'(t - i);
          end
        end
        sb_push(EV_FEED, 2 + t, v, a, 0, 1'b0, ac);
      end
      for (int r = 0; r < N; r++)
        sb_push(EV_ROW, w0 + r + ((r >= sr) ? ns : 0), '0, '0, r, 1'b0, ac);
    end
    sb_push(EV_DONE, done_c, '0, '0, 0, !ok, ac);

    for (int c = 0; c <= end_c; c++) begin
      k_len        = (c == 0) ? KW'(k) : 7'd0;
      start        = (c == 0) || (xs && (c == 4 || c == w0 + 1));
      reset        = (ac >= 0) && (c == ac);
      res_wr_ready = !(ns > 0 && c >= st0 && c < st0 + ns);
      @(negedge clk);
      if (ac >= 0 && c == ac + 1) begin
        chk("abort_ctrl_zero", {busy, done, err, array_clr, a_vld, b_vld, res_wr_valid, res_wr_row}, 64'd0);
        chk("abort_addr_zero", {a_rd_addr, b_rd_addr}, 64'd0);
      end
      exp_busy = ok && c >= 1 && c < done_c && (ac < 0 || c <= ac);
      exp_wv   = ok && c >= w0 && c < done_c && (ac < 0 || c <= ac);
      chk("busy", busy, exp_busy);
      chk("res_wr_valid", res_wr_valid, exp_wv);
      if (!done) chk("err_outside_done", err, 1'b0);
      if (res_wr_valid && !res_wr_ready) chk("stall_row_hold", res_wr_row, 64'(sr));
      if (s1 && c >= 2 && c <= 8) chk("s1_a_vld_seq", a_vld, s1_seq[c - 2]);
`ifndef PERF_CNT_EN
      chk("perf_tied_zero", perf_cycles, 32'd0);
`endif
      if (array_clr) sb_take(EV_CLR, c);
      if ((a_vld | b_vld) != '0) sb_take(EV_FEED, c);
      if (res_wr_valid && res_wr_ready) sb_take(EV_ROW, c);
      if (done) sb_take(EV_DONE, c);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    reset = 1'b0;
    res_wr_ready = 1'b1;
    dd = sb.size();
    chk("sb_drained", 64'(dd), 64'd0);
`ifdef PERF_CNT_EN
    if (ac < 0) chk("perf_cycles", perf_cycles, 64'(done_c));
`endif
  endtask

  initial begin
    s1_seq = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
    reset        = 1'b1;
    start        = 1'b0;
    k_len        = 7'd0;
    res_wr_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", {busy, done, err, array_clr, a_vld, b_vld, res_wr_valid, res_wr_row}, 64'd0);
    chk("reset_addr", {a_rd_addr, b_rd_addr}, 64'd0);
    chk("reset_perf", perf_cycles, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_op(4, N, 0, -1, 1'b0, 1'b1);   // basic op, done at cycle 21
    run_op(1, N, 0, -1, 1'b0, 1'b0);   // shortest op, done at cycle 18
    run_op(4, 2, 3, -1, 1'b0, 1'b0);   // 3-cycle stall on row 2
    run_op(0, N, 0, -1, 1'b0, 1'b0);   // invalid: zero
    run_op(65, N, 0, -1, 1'b0, 1'b0);  // invalid: above K_MAX
    run_op(64, N, 0, -1, 1'b0, 1'b0);  // largest legal k
    run_op(3, N, 0, -1, 1'b1, 1'b0);   // start pulses in FEED and WRITE ignored
    run_op(5, N, 0, 4, 1'b0, 1'b0);    // reset during FEED
    run_op(2, 1, 2, -1, 1'b0, 1'b0);   // recovery after abort, with a stall

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
